// File: rtl/mux_n_1_rr.sv
`default_nettype none
// =============================================================================
// mux_n_1_rr : N:1 valid/ready stream mux with registered output stage,
//              selected externally (MODE=0) or by a round-robin arbiter (MODE=1)
// Rev 1.0
// =============================================================================
module mux_n_1_rr #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int MODE  = 1,
  localparam int SEL_W = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [SEL_W-1:0]     sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_W-1:0]     out_src
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SEL_W-1:0] out_src_q,   out_src_d;

  logic             w_load_en;
  logic             w_gnt_vld;
  logic [SEL_W-1:0] w_gnt;
  logic [WIDTH-1:0] w_gnt_data;

  assign w_load_en = !out_valid_q || out_ready;

  generate
    if (MODE == 0) begin : g_sel
      always_comb begin
        w_gnt     = sel;
        w_gnt_vld = 1'b0;
        if (int'(sel) < N) w_gnt_vld = in_valid[sel];
      end
    end else begin : g_rr
      logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;
      logic [SEL_W-1:0] gnt_hi, gnt_lo;
      logic             hi_found;
      logic             w_unused_sel;

      assign w_unused_sel = ^sel;

      // gnt_lo: lowest valid channel overall (wrap case);
      // gnt_hi: lowest valid channel strictly above the pointer.
      always_comb begin
        gnt_hi   = '0;
        gnt_lo   = '0;
        hi_found = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
          if (in_valid[i]) begin
            gnt_lo = SEL_W'(i);
            if (SEL_W'(i) > rr_ptr_q) begin
              gnt_hi   = SEL_W'(i);
              hi_found = 1'b1;
            end
          end
        end
        w_gnt     = hi_found ? gnt_hi : gnt_lo;
        w_gnt_vld = |in_valid;
      end

      assign rr_ptr_d = (w_load_en && w_gnt_vld) ? w_gnt : rr_ptr_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rr_ptr_q <= SEL_W'(N - 1);
        else        rr_ptr_q <= rr_ptr_d;
      end
    end
  endgenerate

  always_comb begin
    w_gnt_data = '0;
    for (int i = 0; i < N; i++) begin
      if (w_gnt == SEL_W'(i)) w_gnt_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Gated by rst_n so no producer sees a handshake while the block is held in reset.
  always_comb begin
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      in_ready[i] = rst_n && w_load_en && w_gnt_vld && (w_gnt == SEL_W'(i));
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    if (w_load_en) begin
      out_valid_d = w_gnt_vld;
      if (w_gnt_vld) begin
        out_data_d = w_gnt_data;
        out_src_d  = w_gnt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;

endmodule
`default_nettype wire
